// File: rtl/cam_match_iter.sv
// Serialises a multi-hot CAM match line into ascending entry indices.
// One index per beat, with last flag and a latched hit count.
module cam_match_iter #(
    parameter int CAM_DEPTH = 16,
    localparam int CAM_INDEX_WIDTH = $clog2(CAM_DEPTH),
    localparam int CNT_WIDTH = $clog2(CAM_DEPTH + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CAM_DEPTH-1:0]       ml_i,
    input  logic                       ml_valid,
    output logic                       ml_ready,
    output logic [CAM_INDEX_WIDTH-1:0] idx_o,
    output logic                       idx_hit,
    output logic                       idx_last,
    output logic                       idx_valid,
    input  logic                       idx_ready,
    output logic [CNT_WIDTH-1:0]       hit_cnt_o
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [CAM_DEPTH-1:0] ONE = CAM_DEPTH'(1);

    state_t                   state_q, state_d;
    logic [CAM_DEPTH-1:0]     pend_q, pend_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic [CAM_INDEX_WIDTH-1:0] low_idx;
    logic [CNT_WIDTH-1:0]     ml_pop;
    logic                     emit;
    logic                     single;
    logic                     accept;
    logic                     xfer;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
        end
    end

    // Descending scan so the lowest set bit wins.
    always_comb begin
        low_idx = '0;
        for (int i = CAM_DEPTH - 1; i >= 0; i--) begin
            if (pend_q[i]) low_idx = CAM_INDEX_WIDTH'(i);
        end
    end

    always_comb begin
        ml_pop = '0;
        for (int i = 0; i < CAM_DEPTH; i++) begin
            ml_pop = ml_pop + CNT_WIDTH'(ml_i[i]);
        end
    end

    assign emit   = (state_q == EMIT);
    assign single = ((pend_q & (pend_q - ONE)) == '0);
    assign xfer   = idx_valid & idx_ready;
    assign accept = ml_valid & ml_ready;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        if (xfer) pend_d = pend_q & (pend_q - ONE);
        if (accept) begin
            pend_d = ml_i;
            cnt_d  = ml_pop;
        end
        unique case (state_q)
            IDLE: if (accept) state_d = EMIT;
            EMIT: if (xfer && idx_last) state_d = accept ? EMIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        idx_valid = emit;
        idx_o     = emit ? low_idx : '0;
        idx_hit   = emit & (|pend_q);
        idx_last  = emit & single;
        hit_cnt_o = cnt_q;
        // Last-beat transfer frees the slot in the same cycle.
        ml_ready  = (state_q == IDLE) | (emit & idx_ready & single);
    end

endmodule

// File: tb/tb_cam_match_iter.sv
// Directed bench for cam_match_iter with hand-computed expectations.
// Inputs change #1 after the rising edge; outputs sampled there too.
module tb_cam_match_iter;

    logic        clk;
    logic        rst;
    logic [15:0] ml_i;
    logic        ml_valid;
    logic        ml_ready;
    logic [3:0]  idx_o;
    logic        idx_hit;
    logic        idx_last;
    logic        idx_valid;
    logic        idx_ready;
    logic [4:0]  hit_cnt_o;

    int checks = 0;
    int errors = 0;

    cam_match_iter #(.CAM_DEPTH(16)) dut (
        .clk(clk),
        .rst(rst),
        .ml_i(ml_i),
        .ml_valid(ml_valid),
        .ml_ready(ml_ready),
        .idx_o(idx_o),
        .idx_hit(idx_hit),
        .idx_last(idx_last),
        .idx_valid(idx_valid),
        .idx_ready(idx_ready),
        .hit_cnt_o(hit_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input string tag, input logic [3:0] i,
                        input logic hit, input logic last,
                        input logic [4:0] cnt);
        chk({tag, "_valid"}, 32'(idx_valid), 32'd1);
        chk({tag, "_idx"}, 32'(idx_o), 32'(i));
        chk({tag, "_hit"}, 32'(idx_hit), 32'(hit));
        chk({tag, "_last"}, 32'(idx_last), 32'(last));
        chk({tag, "_cnt"}, 32'(hit_cnt_o), 32'(cnt));
    endtask

    task automatic accept(input logic [15:0] ml);
        ml_i = ml;
        ml_valid = 1'b1;
        step();
        ml_valid = 1'b0;
    endtask

    logic [3:0] exp8421 [4];

    initial begin
        exp8421 = '{4'd0, 4'd5, 4'd10, 4'd15};
        rst = 1'b1;
        ml_i = '0;
        ml_valid = 1'b0;
        idx_ready = 1'b0;
        #1;
        chk("rst_valid", 32'(idx_valid), 32'd0);
        chk("rst_idx", 32'(idx_o), 32'd0);
        chk("rst_hit", 32'(idx_hit), 32'd0);
        chk("rst_last", 32'(idx_last), 32'd0);
        chk("rst_cnt", 32'(hit_cnt_o), 32'd0);
        chk("rst_mlrdy", 32'(ml_ready), 32'd1);
        step();
        step();
        rst = 1'b0;
        step();

        // Miss line: single beat with hit=0, last=1
        idx_ready = 1'b1;
        accept(16'h0000);
        beat("miss", 4'd0, 1'b0, 1'b1, 5'd0);
        step();
        chk("miss_idle", 32'(idx_valid), 32'd0);
        chk("miss_mlrdy", 32'(ml_ready), 32'd1);

        // Sparse line; ml_i change during EMIT must be ignored
        accept(16'h8421);
        ml_i = 16'hFFFF;
        for (int k = 0; k < 4; k++) begin
            beat("m8421", exp8421[k], 1'b1, k == 3, 5'd4);
            step();
        end
        chk("m8421_end", 32'(idx_valid), 32'd0);

        // Backpressure holds the head beat stable
        idx_ready = 1'b0;
        accept(16'h0006);
        for (int k = 0; k < 3; k++) begin
            beat("bp_hold", 4'd1, 1'b1, 1'b0, 5'd2);
            chk("bp_mlrdy", 32'(ml_ready), 32'd0);
            step();
        end
        idx_ready = 1'b1;
        beat("bp_b0", 4'd1, 1'b1, 1'b0, 5'd2);
        step();
        beat("bp_b1", 4'd2, 1'b1, 1'b1, 5'd2);
        step();
        chk("bp_end", 32'(idx_valid), 32'd0);

        // Back-to-back: second line accepted on last-beat transfer
        accept(16'h0010);
        ml_i = 16'h0001;
        ml_valid = 1'b1;
        beat("b2b_a", 4'd4, 1'b1, 1'b1, 5'd1);
        chk("b2b_mlrdy", 32'(ml_ready), 32'd1);
        step();
        ml_valid = 1'b0;
        beat("b2b_b", 4'd0, 1'b1, 1'b1, 5'd1);
        step();
        chk("b2b_end", 32'(idx_valid), 32'd0);

        // Full line
        accept(16'hFFFF);
        for (int k = 0; k < 16; k++) begin
            beat("full", 4'(k), 1'b1, k == 15, 5'd16);
            step();
        end
        chk("full_end", 32'(idx_valid), 32'd0);

        // Reset mid-emission discards remaining beats
        accept(16'h00F0);
        beat("rm_b4", 4'd4, 1'b1, 1'b0, 5'd4);
        step();
        beat("rm_b5", 4'd5, 1'b1, 1'b0, 5'd4);
        step();
        chk("rm_pre", 32'(idx_o), 32'd6);
        rst = 1'b1;
        #1;
        chk("rm_valid", 32'(idx_valid), 32'd0);
        chk("rm_mlrdy", 32'(ml_ready), 32'd1);
        chk("rm_cnt", 32'(hit_cnt_o), 32'd0);
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("rm_after_valid", 32'(idx_valid), 32'd0);
            chk("rm_after_mlrdy", 32'(ml_ready), 32'd1);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
